// File: rtl/regfile_wb_arbiter.sv
// Write-port sequencer for the 32x32 register file: clears registers 1..NUM_REGS-1
// after reset or on request, then round-robin arbitrates two writeback requesters.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              regfile_wren,
  output logic [ADDR_W-1:0] write_addr3,
  output logic [DATA_W-1:0] regfile_data_in3,
  output logic              grant_id
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic              prio;
  logic              grant0, grant1;
  logic              last_clear;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign last_clear = (cnt == ADDR_W'(NUM_REGS - 1));
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;
  assign init_busy  = (state == S_INIT);
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      S_INIT: if (last_clear) state_next = S_RUN;
      S_RUN: begin
        if (init_start) begin
          state_next = S_INIT;
        end else begin
          grant0 = req0_valid & (~req1_valid | ~prio);
          grant1 = req1_valid & (~req0_valid |  prio);
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= ADDR_W'(1);
      prio             <= 1'b0;
      regfile_wren     <= 1'b0;
      write_addr3      <= '0;
      regfile_data_in3 <= '0;
      grant_id         <= 1'b0;
      init_done        <= 1'b0;
    end else begin
      regfile_wren <= 1'b0;
      init_done    <= 1'b0;
      if (state == S_INIT) begin
        regfile_wren     <= 1'b1;
        write_addr3      <= cnt;
        regfile_data_in3 <= '0;
        // Reload on the last clear so any later INIT entry starts at register 1.
        cnt              <= last_clear ? ADDR_W'(1) : cnt + 1'b1;
        init_done        <= last_clear;
      end else if (grant0 || grant1) begin
        prio     <= grant0;
        grant_id <= grant1;
        // Register 0 is hardwired zero: the transfer is consumed but never written.
        if (sel_addr != '0) begin
          regfile_wren     <= 1'b1;
          write_addr3      <= sel_addr;
          regfile_data_in3 <= sel_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter against a queue-based
// behavioural model and a shadow register file written from the DUT port.
module tb_regfile_wb_arbiter;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_start = 1'b0;
  logic        init_busy, init_done;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        regfile_wren;
  logic [4:0]  write_addr3;
  logic [31:0] regfile_data_in3;
  logic        grant_id;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .init_busy(init_busy), .init_done(init_done),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .regfile_wren(regfile_wren), .write_addr3(write_addr3),
    .regfile_data_in3(regfile_data_in3), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Shadow register file driven only by the DUT write port.
  logic [31:0] tb_rf [32];
  always @(posedge clk)
    if (regfile_wren && write_addr3 != 5'd0) tb_rf[write_addr3] <= regfile_data_in3;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model
  wr_t         q0[$], q1[$];
  logic [31:0] exp_rf [32];
  bit          m_init;
  int          m_idx, m_prio;
  bit          e_wren, e_gid, e_done;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  bit          obs_busy;

  task automatic model_reset();
    m_init = 1; m_idx = 1; m_prio = 0;
    e_wren = 0; e_addr = '0; e_data = '0; e_gid = 0; e_done = 0;
  endtask

  // One clock cycle: present queue heads at posedge+1, check at negedge,
  // advance the model at the next posedge.
  task automatic cycle(input bit start);
    bit  v0, v1;
    int  g;
    wr_t w;
    v0 = q0.size() > 0;
    v1 = q1.size() > 0;
    req0_valid = v0;
    req1_valid = v1;
    req0_addr  = v0 ? q0[0].a : 5'($urandom);
    req0_data  = v0 ? q0[0].d : $urandom;
    req1_addr  = v1 ? q1[0].a : 5'($urandom);
    req1_data  = v1 ? q1[0].d : $urandom;
    init_start = start;
    g = -1;
    if (!m_init && !start && (v0 || v1)) g = (v0 && v1) ? m_prio : (v0 ? 0 : 1);

    @(negedge clk);
    obs_busy = init_busy;
    check("init_busy", init_busy, m_init);
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    check("wren", regfile_wren, e_wren);
    if (e_wren) begin
      check("waddr", write_addr3, e_addr);
      check("wdata", regfile_data_in3, e_data);
    end
    check("grant_id", grant_id, e_gid);
    check("init_done", init_done, e_done);

    @(posedge clk);
    e_done = 0;
    if (m_init) begin
      e_wren = 1; e_addr = 5'(m_idx); e_data = '0;
      exp_rf[m_idx] = '0;
      if (m_idx == 31) begin m_init = 0; e_done = 1; end
      m_idx++;
    end else if (start) begin
      m_init = 1; m_idx = 1; e_wren = 0;
    end else if (g >= 0) begin
      w = (g == 0) ? q0.pop_front() : q1.pop_front();
      e_gid  = (g == 1);
      m_prio = 1 - g;
      e_wren = (w.a != 5'd0);
      if (e_wren) begin
        e_addr = w.a; e_data = w.d;
        exp_rf[w.a] = w.d;
      end
    end else begin
      e_wren = 0;
    end
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((q0.size() + q1.size()) > 0 && n < max_cycles) begin
      cycle(0);
      n++;
    end
    check("drain_left", q0.size() + q1.size(), 0);
    cycle(0);
    cycle(0);
  endtask

  task automatic rf_check(input string tag);
    for (int i = 0; i < 32; i++)
      if (tb_rf[i] !== exp_rf[i]) check({tag, "_rf"}, {27'd0, 5'(i), tb_rf[i]}, {27'd0, 5'(i), exp_rf[i]});
    check({tag, "_r0"}, tb_rf[0], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wr_t w;
    tb_rf[0] = '0;
    exp_rf[0] = '0;
    model_reset();

    #2;
    check("rst_wren", regfile_wren, 0);
    check("rst_waddr", write_addr3, 0);
    check("rst_wdata", regfile_data_in3, 0);
    check("rst_gid", grant_id, 0);
    check("rst_done", init_done, 0);
    check("rst_busy", init_busy, 1);

    // Requests pending through INIT; readies must stay low until RUN.
    q0.push_back('{5'd5, 32'hDEADBEEF});
    q1.push_back('{5'd9, 32'h0000_0099});
    #14 rst_n = 1'b1;
    for (int i = 0; i < 31; i++) cycle(0);
    drain(10);
    rf_check("single");
    check("r5", tb_rf[5], 32'hDEADBEEF);

    // Alternating grants under continuous contention.
    for (int i = 1; i <= 4; i++) begin
      q0.push_back('{5'(i), 32'(i + 100)});
      q1.push_back('{5'(i + 10), 32'(i + 110)});
    end
    drain(20);
    rf_check("rr");
    check("r14", tb_rf[14], 32'd114);

    // Register-0 write is consumed without a regfile write.
    q1.push_back('{5'd0, 32'h1234});
    drain(5);
    check("gid_r0", grant_id, 1);
    rf_check("zero");

    // init_start in RUN blocks the pending request until the clear finishes.
    q0.push_back('{5'd7, 32'h77});
    cycle(1);
    drain(60);
    rf_check("reinit");
    check("r7", tb_rf[7], 32'h77);
    check("r5_cleared", tb_rf[5], 32'd0);

    // Randomized traffic with occasional re-clear requests.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(1, 0) == 1 && q0.size() < 3) begin
        w.a = 5'($urandom_range(31, 0)); w.d = $urandom; q0.push_back(w);
      end
      if ($urandom_range(1, 0) == 1 && q1.size() < 3) begin
        w.a = 5'($urandom_range(31, 0)); w.d = $urandom; q1.push_back(w);
      end
      cycle($urandom_range(59, 0) == 0);
    end
    drain(200);
    rf_check("random");

    // Asynchronous reset mid-INIT right after addr 10 is issued.
    cycle(1);
    n = 0;
    while (!(m_init && e_addr == 5'd10 && e_wren) && n < 40) begin
      cycle(0);
      n++;
    end
    check("reach_addr10", write_addr3, 5'd10);
    #2 rst_n = 1'b0;
    #1;
    check("async_wren", regfile_wren, 0);
    check("async_waddr", write_addr3, 0);
    check("async_busy", init_busy, 1);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0);
      if (obs_busy) n++;
    end
    check("init_len", n, 31);
    rf_check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences and shares the single write port (port 3) of the 32x32 register file of the single-cycle core.
- Clears registers 1..31 to zero after reset and on request (INIT sequence).
- Arbitrates between two writeback requesters (e.g. ALU/load writeback and CSR/debug writer) with valid/ready handshakes and round-robin fairness.
- Drives the regfile write-side signals directly from registered outputs.

Parameters:
- DATA_W, 32, width of register data.
- ADDR_W, 5, width of register address.
- NUM_REGS, 32, number of registers; register 0 is hardwired zero.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_start  in  1  request a re-clear of registers 1..NUM_REGS-1.
- init_busy  out  1  high while the INIT sequence runs.
- init_done  out  1  one-cycle pulse when INIT completes.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req1_valid  in  1  requester 1 has a write pending.
- req1_ready  out  1  requester 1 write accepted this cycle.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- regfile_wren  out  1  regfile write enable (registered).
- write_addr3  out  ADDR_W  regfile write address (registered).
- regfile_data_in3  out  DATA_W  regfile write data (registered).
- grant_id  out  1  requester of the most recent accepted transfer (registered).

Behaviour:
- Reset (asynchronous, immediate, no clock required):
  - regfile_wren=0, write_addr3=0, regfile_data_in3=0, grant_id=0, init_done=0.
  - Round-robin pointer prio=0.
  - FSM enters INIT with cnt=1.
- FSM has two states, INIT and RUN.
- INIT:
  - init_busy=1; req0_ready=req1_ready=0; init_start is ignored.
  - Each edge registers wren=1, addr=cnt, data=0, then cnt increments.
  - When cnt==NUM_REGS-1 is issued, the next state is RUN.
  - This gives exactly NUM_REGS-1 (31) consecutive write cycles.
  - init_done is registered and high for exactly the first RUN cycle.
- RUN, with init_start=1:
  - Both readies are 0 and no grant is made.
  - Next state is INIT with cnt=1, and prio is kept.
  - An output write registered on the same edge (from the previous cycle's grant) still completes.
- RUN, with init_start=0:
  - Grant logic is combinational.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester indicated by prio is granted.
  - reqN_ready = grant to N; at most one ready per cycle.
  - Transfer occurs on valid&ready at an edge.
  - After each transfer, prio = the other requester, and grant_id = the granted requester.
- Write latency:
  - For a transfer at edge k: during cycle k..k+1, regfile_wren=1 with the captured addr/data.
  - The regfile is updated at edge k+1.
  - Sustained throughput is one write per cycle.
- Writes to address 0:
  - The transfer is accepted (ready=1), and prio and grant_id update.
  - regfile_wren stays 0.
- No grant in a cycle: regfile_wren=0 next cycle; addr/data outputs hold their previous values.
- Requesters must hold addr/data stable while valid and not ready. The arbiter does not buffer, so there is no full/empty condition.
- Reset asserted mid-INIT or mid-write: all in-flight state is discarded. After release, INIT restarts from register 1.

Test Plan:
- Release rst_n, keep req0/1_valid=1 -> 31 consecutive cycles with wren=1, addr 1..31, data 0; both readies 0 throughout; init_done high for one cycle after addr 31; all regfile registers then read 0.
- After INIT, req0 addr=5 data=0xDEADBEEF -> req0_ready=1 the same cycle; next cycle wren=1, write_addr3=5, data_in3=0xDEADBEEF; port 1 then reads 0xDEADBEEF from register 5.
- Both valid continuously, req0 addrs 1,2,3,4 and req1 addrs 11,12,13,14, data=addr+100 -> grants 0,1,0,1,... with one wren per cycle; registers 1..4 and 11..14 hold addr+100.
- req1 addr=0 data=0x1234 -> req1_ready=1, regfile_wren stays 0, register 0 reads 0, grant_id=1.
- In RUN, pulse init_start together with req0 valid (addr 7, data 0x77) -> req0_ready=0 that cycle; 31 clear writes follow; then req0 completes and register 7 reads 0x77 while previously written registers read 0.
- Assert rst_n=0 mid-INIT at addr 10, between edges -> regfile_wren falls to 0 immediately; after release, the sequence restarts at addr 1 and still takes 31 cycles.
